// File: rtl/systolic_pkg.sv
// Shared types and latency constants for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} sctrl_state_t;

    // Accept-to-result latency through input skew, array and output deskew.
    function automatic int res_lat(input int r, input int c);
        return r + c;
    endfunction

    localparam int DRAIN_PAD = 1;

    function automatic int drain_cycles(input int r, input int c);
        return res_lat(r, c) + DRAIN_PAD;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth shift register carrying a data word and its enable tag.
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk_in,
    input  logic         nrst_in,
    input  logic [W-1:0] d,
    input  logic         tag_d,
    output logic [W-1:0] q,
    output logic         tag_q
);

    logic [DEPTH-1:0][W-1:0] data_sr;
    logic [DEPTH-1:0]        tag_sr;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            data_sr <= '0;
            tag_sr  <= '0;
        end else begin
            data_sr[0] <= d;
            tag_sr[0]  <= tag_d;
            for (int k = 1; k < DEPTH; k++) begin
                data_sr[k] <= data_sr[k-1];
                tag_sr[k]  <= tag_sr[k-1];
            end
        end
    end

    assign q     = data_sr[DEPTH-1];
    assign tag_q = tag_sr[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, skewed feature
// streaming, output deskew and job completion.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int width = 8,
    parameter int row   = 4,
    parameter int col   = 4,
    parameter int cnt_w = 8
) (
    input  logic                       clk_in,
    input  logic                       nrst_in,
    input  logic                       start,
    input  logic [cnt_w-1:0]           num_vec,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [col-1:0][width-1:0]  w_data,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [row-1:0][width-1:0]  f_data,
    output logic                       arr_ctrl,
    output logic [col-1:0]             arr_weight_en,
    output logic [col-1:0][width-1:0]  arr_weight,
    output logic [row-1:0]             arr_in_en,
    output logic [row-1:0][width-1:0]  arr_feature,
    input  logic [col-1:0][width-1:0]  arr_out,
    output logic                       res_valid,
    output logic [col-1:0][width-1:0]  res_data,
    output logic                       busy,
    output logic                       done
);

    localparam int BEAT_W  = $clog2(row) + 1;
    localparam int DRAIN_N = drain_cycles(row, col);
    localparam int DRAIN_W = $clog2(DRAIN_N) + 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(row - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_N - 1);

    sctrl_state_t        state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [cnt_w-1:0]    vec_cnt, vec_cnt_nxt;
    logic [cnt_w-1:0]    num_vec_q, num_vec_nxt;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic                w_acc, f_acc;

    assign w_ready  = (state == LOAD_W);
    assign f_ready  = (state == STREAM);
    assign arr_ctrl = (state == LOAD_W);
    assign busy     = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
    assign done     = (state == DONE);
    assign w_acc    = w_ready && w_valid;
    assign f_acc    = f_ready && f_valid;

    assign arr_weight_en = {col{w_acc}};
    assign arr_weight    = w_acc ? w_data : '0;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            vec_cnt   <= '0;
            num_vec_q <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            vec_cnt   <= vec_cnt_nxt;
            num_vec_q <= num_vec_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        vec_cnt_nxt   = vec_cnt;
        num_vec_nxt   = num_vec_q;
        drain_cnt_nxt = drain_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = LOAD_W;
                    num_vec_nxt  = num_vec;
                    beat_cnt_nxt = '0;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            LOAD_W: begin
                if (w_valid) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt     = (num_vec_q == '0) ? DRAIN : STREAM;
                        vec_cnt_nxt   = '0;
                        drain_cnt_nxt = '0;
                    end
                end
            end
            STREAM: begin
                if (f_valid) begin
                    vec_cnt_nxt = vec_cnt + 1'b1;
                    if (vec_cnt == num_vec_q - 1'b1) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = '0;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt + 1'b1;
                if (drain_cnt == LAST_DRAIN) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane i reaches the array i+1 cycles after accept; bubbles carry a zero tag.
    for (genvar i = 0; i < row; i++) begin : g_in_skew
        skew_line #(.DEPTH(i + 1), .W(width)) u_skew (
            .clk_in  (clk_in),
            .nrst_in (nrst_in),
            .d       (f_acc ? f_data[i] : '0),
            .tag_d   (f_acc),
            .q       (arr_feature[i]),
            .tag_q   (arr_in_en[i])
        );
    end

    // Last lane's tag marks when column 0 presents a result; column j is j later.
    logic [col-1:0] vld_pipe;
    logic [col-2:0] vld_sr;

    assign vld_pipe = {vld_sr, arr_in_en[row-1]};

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) vld_sr <= '0;
        else          vld_sr <= vld_pipe[col-2:0];
    end

    // Column j waits col-j cycles so every column lands in the same output register.
    logic [col-1:0] res_tag;

    for (genvar j = 0; j < col; j++) begin : g_deskew
        skew_line #(.DEPTH(col - j), .W(width)) u_deskew (
            .clk_in  (clk_in),
            .nrst_in (nrst_in),
            .d       (vld_pipe[j] ? arr_out[j] : '0),
            .tag_d   (vld_pipe[j]),
            .q       (res_data[j]),
            .tag_q   (res_tag[j])
        );
    end

    assign res_valid = &res_tag;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a behavioural weight-stationary array.
module tb_systolic_ctrl;

    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int W   = 8;
    localparam int CW  = 8;
    localparam int H   = ROW + COL - 2;

    typedef logic [ROW-1:0][W-1:0] fvec_t;
    typedef logic [COL-1:0][W-1:0] rvec_t;

    logic           clk_in = 1'b0;
    logic           nrst_in, start, w_valid, f_valid;
    logic [CW-1:0]  num_vec;
    rvec_t          w_data, arr_weight, arr_out, res_data;
    fvec_t          f_data, arr_feature;
    logic           w_ready, f_ready, arr_ctrl, res_valid, busy, done;
    logic [COL-1:0] arr_weight_en;
    logic [ROW-1:0] arr_in_en;
    int             cyc = 0;

    systolic_ctrl #(.width(W), .row(ROW), .col(COL), .cnt_w(CW)) dut (
        .clk_in(clk_in), .nrst_in(nrst_in), .start(start), .num_vec(num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .arr_ctrl(arr_ctrl), .arr_weight_en(arr_weight_en), .arr_weight(arr_weight),
        .arr_in_en(arr_in_en), .arr_feature(arr_feature), .arr_out(arr_out),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Array model: beat k loads row k; column j of the vector accepted at T
    // appears combinationally at T+ROW+j from the skewed lanes.
    rvec_t wm [ROW];
    int    wcnt;
    fvec_t hist [1:H];
    fvec_t hf [0:H];

    always @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wcnt <= 0;
            for (int k = 0; k < ROW; k++) wm[k] <= '0;
            for (int d = 1; d <= H; d++) hist[d] <= '0;
        end else begin
            if (|arr_weight_en) begin
                for (int j = 0; j < COL; j++)
                    if (arr_weight_en[j]) wm[wcnt][j] <= arr_weight[j];
                wcnt <= (wcnt == ROW - 1) ? 0 : wcnt + 1;
            end
            hist[1] <= arr_feature;
            for (int d = 2; d <= H; d++) hist[d] <= hist[d-1];
        end
    end

    always_comb begin
        hf[0] = arr_feature;
        for (int d = 1; d <= H; d++) hf[d] = hist[d];
        for (int j = 0; j < COL; j++) begin
            arr_out[j] = '0;
            for (int i = 0; i < ROW; i++)
                arr_out[j] = arr_out[j] + wm[i][j] * hf[ROW-1+j-i][i];
        end
    end

    int checks = 0;
    int errors = 0;

    fvec_t          feats [8];
    rvec_t          wts [ROW];
    int             acc_c [8];
    int             res_c [8];
    rvec_t          res_v [8];
    logic [ROW-1:0] en_log [64];
    int             n_acc, n_res, n_done, done_c, n_fr_after, base_c;

    task automatic do_start(input int n);
        start = 1'b1;
        num_vec = CW'(n);
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic load_w(output int last_c);
        last_c = -1;
        for (int k = 0; k < ROW; k++) begin
            w_valid = 1'b1;
            w_data  = wts[k];
            last_c  = cyc;
            @(negedge clk_in);
        end
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    // Drives a feature valid pattern and logs accepts, results and done for 40 more cycles.
    task automatic collect(input int npat, input logic [7:0] pat, input int start_at);
        n_acc = 0; n_res = 0; n_done = 0; done_c = -1; n_fr_after = 0; base_c = cyc;
        for (int k = 0; k < 8; k++) begin acc_c[k] = -1; res_c[k] = -1; res_v[k] = '0; end
        for (int s = 0; s < npat + 40; s++) begin
            f_valid = (s < npat) ? pat[s] : 1'b0;
            f_data  = feats[n_acc < 8 ? n_acc : 7];
            start   = (s == start_at);
            num_vec = 8'd7;
            #1;
            if (s < npat && pat[s] && f_ready === 1'b1 && n_acc < 8) begin
                acc_c[n_acc] = cyc;
                n_acc++;
            end
            if (s >= npat && f_ready === 1'b1) n_fr_after++;
            if (res_valid === 1'b1 && n_res < 8) begin
                res_c[n_res] = cyc;
                res_v[n_res] = res_data;
                n_res++;
            end
            if (done === 1'b1) begin n_done++; done_c = cyc; end
            if (s < 64) en_log[s] = arr_in_en;
            @(negedge clk_in);
        end
        start = 1'b0;
        f_valid = 1'b0;
    endtask

    task automatic set_identity();
        for (int k = 0; k < ROW; k++)
            for (int j = 0; j < COL; j++) wts[k][j] = (k == j) ? 8'd1 : 8'd0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < ROW; i++) feats[k][i] = 8'(4 * k + i + 1);
    endtask

    task automatic test_reset();
        nrst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        checks++;
        if ({w_ready, f_ready, arr_ctrl, res_valid, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {w_ready, f_ready, arr_ctrl, res_valid, busy, done});
        end
        checks++;
        if (arr_weight_en !== '0 || arr_in_en !== '0) begin
            errors++;
            $display("FAIL reset_en: got %h/%h expected 0/0", arr_weight_en, arr_in_en);
        end
        checks++;
        if (arr_weight !== '0 || arr_feature !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", arr_weight, arr_feature, res_data);
        end
        nrst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (busy !== 1'b0 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b w_ready=%b expected 0 0", busy, w_ready);
        end
    endtask

    task automatic test_identity();
        int lc;
        set_identity();
        do_start(4);
        checks++;
        if ({busy, w_ready, arr_ctrl} !== 3'b111) begin
            errors++;
            $display("FAIL start_to_load: got %b expected 111", {busy, w_ready, arr_ctrl});
        end
        load_w(lc);
        collect(4, 8'h0F, -1);
        checks++;
        if (n_acc !== 4 || n_res !== 4) begin
            errors++;
            $display("FAIL id_count: acc=%0d res=%0d expected 4 4", n_acc, n_res);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_v[k] !== rvec_t'(feats[k]) || res_c[k] !== base_c + k + 8) begin
                errors++;
                $display("FAIL id_res%0d: got %h @%0d expected %h @%0d",
                         k, res_v[k], res_c[k], feats[k], base_c + k + 8);
            end
        end
        checks++;
        if (n_done !== 1 || done_c !== base_c + 3 + 10) begin
            errors++;
            $display("FAIL id_done: got %0d pulses @%0d expected 1 @%0d",
                     n_done, done_c, base_c + 13);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL id_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_w_gaps();
        logic [6:0] wp = 7'b1011001;
        int k = 0;
        int pulses = 0;
        for (int b = 0; b < ROW; b++)
            for (int j = 0; j < COL; j++) wts[b][j] = 8'(b + 1);
        for (int i = 0; i < ROW; i++) feats[0][i] = 8'd1;
        do_start(1);
        for (int s = 0; s < 7; s++) begin
            w_valid = wp[s];
            w_data  = wp[s] ? wts[k] : {COL{8'hEE}};
            #1;
            checks++;
            if (arr_ctrl !== 1'b1 || w_ready !== 1'b1 || arr_weight_en !== (wp[s] ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL wgap_ctl%0d: ctrl=%b rdy=%b en=%h expected 1 1 %h",
                         s, arr_ctrl, w_ready, arr_weight_en, wp[s] ? 4'hF : 4'h0);
            end
            if (|arr_weight_en) pulses++;
            if (wp[s]) begin
                checks++;
                if (arr_weight !== wts[k]) begin
                    errors++;
                    $display("FAIL wgap_data%0d: got %h expected %h", k, arr_weight, wts[k]);
                end
                k++;
            end
            @(negedge clk_in);
        end
        w_valid = 1'b0;
        w_data  = '0;
        checks++;
        if (pulses !== 4 || arr_ctrl !== 1'b0 || f_ready !== 1'b1) begin
            errors++;
            $display("FAIL wgap_end: pulses=%0d ctrl=%b f_ready=%b expected 4 0 1",
                     pulses, arr_ctrl, f_ready);
        end
        collect(1, 8'h01, -1);
        checks++;
        if (n_res !== 1 || res_v[0] !== {COL{8'd10}} || res_c[0] !== base_c + 8) begin
            errors++;
            $display("FAIL wgap_res: got %0d x %h @%0d expected 1 x 0a0a0a0a @%0d",
                     n_res, res_v[0], res_c[0], base_c + 8);
        end
        checks++;
        if (n_done !== 1 || done_c !== base_c + 10) begin
            errors++;
            $display("FAIL wgap_done: got %0d @%0d expected 1 @%0d", n_done, done_c, base_c + 10);
        end
    endtask

    task automatic test_bubble();
        int lc;
        logic [7:0] bp = 8'h0D;
        logic [ROW-1:0] exp_en;
        int exp_c [3] = '{8, 10, 11};
        set_identity();
        do_start(3);
        load_w(lc);
        collect(4, bp, -1);
        checks++;
        if (n_res !== 3) begin
            errors++;
            $display("FAIL bub_count: got %0d expected 3", n_res);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_v[k] !== rvec_t'(feats[k]) || res_c[k] !== base_c + exp_c[k]) begin
                errors++;
                $display("FAIL bub_res%0d: got %h @%0d expected %h @%0d",
                         k, res_v[k], res_c[k], feats[k], base_c + exp_c[k]);
            end
        end
        for (int s = 0; s < 10; s++) begin
            exp_en = '0;
            for (int i = 0; i < ROW; i++)
                if (s - 1 - i >= 0 && s - 1 - i < 4) exp_en[i] = bp[s-1-i];
            checks++;
            if (en_log[s] !== exp_en) begin
                errors++;
                $display("FAIL bub_diag%0d: got %b expected %b", s, en_log[s], exp_en);
            end
        end
        checks++;
        if (n_done !== 1 || done_c !== base_c + 13) begin
            errors++;
            $display("FAIL bub_done: got %0d @%0d expected 1 @%0d", n_done, done_c, base_c + 13);
        end
    endtask

    task automatic test_zero_vec();
        int lc;
        set_identity();
        do_start(0);
        load_w(lc);
        collect(0, 8'h00, -1);
        checks++;
        if (n_fr_after !== 0 || n_res !== 0) begin
            errors++;
            $display("FAIL zero_stream: f_ready cycles=%0d results=%0d expected 0 0", n_fr_after, n_res);
        end
        checks++;
        if (n_done !== 1 || done_c !== lc + 10) begin
            errors++;
            $display("FAIL zero_done: got %0d @%0d expected 1 @%0d", n_done, done_c, lc + 10);
        end
    endtask

    task automatic test_start_ignored();
        int lc;
        set_identity();
        do_start(2);
        load_w(lc);
        collect(2, 8'h03, 1);
        checks++;
        if (n_acc !== 2 || n_res !== 2 || n_fr_after !== 0) begin
            errors++;
            $display("FAIL ign_count: acc=%0d res=%0d extra_ready=%0d expected 2 2 0",
                     n_acc, n_res, n_fr_after);
        end
        checks++;
        if (res_v[1] !== rvec_t'(feats[1]) || res_c[1] !== base_c + 9) begin
            errors++;
            $display("FAIL ign_res: got %h @%0d expected %h @%0d",
                     res_v[1], res_c[1], feats[1], base_c + 9);
        end
        checks++;
        if (n_done !== 1 || done_c !== base_c + 11) begin
            errors++;
            $display("FAIL ign_done: got %0d @%0d expected 1 @%0d", n_done, done_c, base_c + 11);
        end
    endtask

    task automatic test_reset_mid();
        int lc;
        int nv = 0;
        int nd = 0;
        set_identity();
        do_start(6);
        load_w(lc);
        for (int s = 0; s < 3; s++) begin
            f_valid = 1'b1;
            f_data  = feats[s];
            @(negedge clk_in);
        end
        f_valid = 1'b0;
        nrst_in = 1'b0;
        #1;
        checks++;
        if ({w_ready, f_ready, arr_ctrl, res_valid, busy, done} !== 6'b0 ||
            arr_weight_en !== '0 || arr_in_en !== '0) begin
            errors++;
            $display("FAIL mid_rst_ctrl: got %b en=%h/%h expected all 0",
                     {w_ready, f_ready, arr_ctrl, res_valid, busy, done}, arr_weight_en, arr_in_en);
        end
        checks++;
        if (arr_weight !== '0 || arr_feature !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL mid_rst_data: got %h/%h/%h expected 0", arr_weight, arr_feature, res_data);
        end
        @(negedge clk_in);
        nrst_in = 1'b1;
        for (int s = 0; s < 20; s++) begin
            #1;
            if (res_valid === 1'b1) nv++;
            if (done === 1'b1 || busy === 1'b1) nd++;
            @(negedge clk_in);
        end
        checks++;
        if (nv !== 0 || nd !== 0) begin
            errors++;
            $display("FAIL mid_rst_quiet: res_valid=%0d done_or_busy=%0d expected 0 0", nv, nd);
        end
        do_start(2);
        load_w(lc);
        collect(2, 8'h03, -1);
        checks++;
        if (n_res !== 2 || res_v[0] !== rvec_t'(feats[0]) || res_v[1] !== rvec_t'(feats[1])) begin
            errors++;
            $display("FAIL mid_rst_rerun: got %0d %h %h expected 2 %h %h",
                     n_res, res_v[0], res_v[1], feats[0], feats[1]);
        end
        checks++;
        if (n_done !== 1 || done_c !== base_c + 11) begin
            errors++;
            $display("FAIL mid_rst_done: got %0d @%0d expected 1 @%0d", n_done, done_c, base_c + 11);
        end
    endtask

    initial begin
        start = 1'b0; num_vec = '0; w_valid = 1'b0; w_data = '0;
        f_valid = 1'b0; f_data = '0;
        test_reset();
        test_identity();
        test_w_gaps();
        test_bubble();
        test_zero_vec();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
